// File: rtl/uart_rx_cfg.sv
// UART receiver with mid-bit sampling from a baud down-counter, configurable word
// length and parity, and frame/parity/overrun status held alongside the received word.
module uart_rx_cfg #(
  parameter int BAUD_DIV  = 2604,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int            CW         = $clog2(BAUD_DIV);
  localparam int            BW         = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_CNT   = CW'(BAUD_DIV / 32'sd2);
  localparam logic [CW-1:0] RELOAD_CNT = CW'(BAUD_DIV - 32'sd1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 32'sd1);
  localparam logic          HAS_PAR    = (PARITY != 32'sd0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } state_t;

  state_t               state_r;
  logic                 rx_meta_r;
  logic                 rx_s;
  logic [CW-1:0]        baud_cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_err_r;
  logic                 sample_s;

  // Odd mode flags an even count of ones over data+parity; even mode flags an odd count.
  function automatic logic parity_check(input logic [DATA_BITS-1:0] data, input logic pbit);
    logic x;
    x = ^{data, pbit};
    if (PARITY == 32'sd1) begin
      return ~x;
    end else if (PARITY == 32'sd2) begin
      return x;
    end else begin
      return 1'b0;
    end
  endfunction

  assign sample_s = (baud_cnt_r == {CW{1'b0}});

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_s      <= rx_meta_r;
    end
  end

  // Frame sequencer: baud timing, bit capture and status update at the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= HALF_CNT;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      par_err_r  <= 1'b0;
      rx_data    <= '0;
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clr_rdy) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end

      // Idle and break hold the half-bit preset so the next start is sampled mid-bit.
      if (state_r == IDLE || state_r == BREAK) begin
        baud_cnt_r <= HALF_CNT;
      end else if (sample_s) begin
        baud_cnt_r <= RELOAD_CNT;
      end else begin
        baud_cnt_r <= baud_cnt_r - CW'(1'b1);
      end

      case (state_r)
        IDLE: begin
          if (!rx_s) state_r <= START;
        end
        START: begin
          if (sample_s) begin
            if (rx_s) begin
              state_r <= IDLE;
            end else begin
              state_r   <= DATA;
              bit_cnt_r <= '0;
            end
          end
        end
        DATA: begin
          if (sample_s) begin
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= '0;
              state_r   <= HAS_PAR ? PAR : STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BW'(1'b1);
            end
          end
        end
        PAR: begin
          if (sample_s) begin
            par_err_r <= parity_check(shift_r, rx_s);
            state_r   <= STOP;
          end
        end
        STOP: begin
          // A completing word overrides a simultaneous clr_rdy.
          if (sample_s) begin
            rx_data    <= shift_r;
            parity_err <= HAS_PAR ? par_err_r : 1'b0;
            frame_err  <= ~rx_s;
            rdy        <= 1'b1;
            overrun    <= overrun | rdy;
            state_r    <= rx_s ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (rx_s) state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: one no-parity and one even-parity receiver,
// each on its own serial line, sharing clock, reset and clr_rdy.
module tb_uart_rx_cfg;

  localparam int D = 16;
  localparam int H = D / 2;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_rdy = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] data0, data2;
  logic       rdy0, rdy2, perr0, perr2, ferr0, ferr2, ovr0, ovr2;

  uart_rx_cfg #(.BAUD_DIV(D), .DATA_BITS(N), .PARITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .RX(rx0), .clr_rdy(clr_rdy), .rx_data(data0),
    .rdy(rdy0), .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0)
  );

  uart_rx_cfg #(.BAUD_DIV(D), .DATA_BITS(N), .PARITY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .RX(rx2), .clr_rdy(clr_rdy), .rx_data(data2),
    .rdy(rdy2), .parity_err(perr2), .frame_err(ferr2), .overrun(ovr2)
  );

  typedef struct {
    bit         sel;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc[2];
  int   rise_cyc[2];
  logic rdy_prev[2];
  logic rdy_m[2];
  logic ovr_m[2];

  always #5 clk = ~clk;

  // Free-running edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Records the edge count at which each rdy first rises.
  initial begin
    rdy_prev = '{1'b0, 1'b0};
    rise_cyc = '{0, 0};
    forever begin
      @(negedge clk);
      if (rdy0 && !rdy_prev[0]) rise_cyc[0] = cyc;
      if (rdy2 && !rdy_prev[1]) rise_cyc[1] = cyc;
      rdy_prev[0] = rdy0;
      rdy_prev[1] = rdy2;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic b);
    if (sel) rx2 = b;
    else     rx0 = b;
    repeat (D) @(negedge clk);
  endtask

  // Push the expected result, then drive start, data LSB first, optional parity, stop.
  task automatic send_frame(input bit sel, input logic [7:0] data, input logic pbit, input logic stop);
    exp_t e;
    e.sel  = sel;
    e.data = data;
    e.perr = sel ? (^{data, pbit}) : 1'b0;
    e.ferr = ~stop;
    e.ovr  = ovr_m[sel] | rdy_m[sel];
    ovr_m[sel] = e.ovr;
    rdy_m[sel] = 1'b1;
    sb.push_back(e);
    start_cyc[sel] = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < N; i++) drive_bit(sel, data[i]);
    if (sel) drive_bit(sel, pbit);
    drive_bit(sel, stop);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    int   t;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, sb.size(), 1);
      return;
    end
    // On overrun the older words are overwritten; only the newest is visible.
    while (sb.size() > 1) sb.delete(0);
    e = sb.pop_front();
    t = 0;
    while ((e.sel ? rdy2 : rdy0) !== 1'b1 && t < 4 * D) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_rdy"},  e.sel ? rdy2  : rdy0,  1'b1);
    chk({tag, "_data"}, e.sel ? data2 : data0, e.data);
    chk({tag, "_perr"}, e.sel ? perr2 : perr0, e.perr);
    chk({tag, "_ferr"}, e.sel ? ferr2 : ferr0, e.ferr);
    chk({tag, "_ovr"},  e.sel ? ovr2  : ovr0,  e.ovr);
  endtask

  task automatic do_clr(input string tag);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    rdy_m = '{1'b0, 1'b0};
    ovr_m = '{1'b0, 1'b0};
    chk({tag, "_rdy0"}, rdy0, rdy_m[0]);
    chk({tag, "_ovr0"}, ovr0, ovr_m[0]);
    chk({tag, "_rdy2"}, rdy2, rdy_m[1]);
    chk({tag, "_ovr2"}, ovr2, ovr_m[1]);
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_rdy"},  rdy0,  1'b0);
    chk({tag, "_data"}, data0, 8'h00);
    chk({tag, "_perr"}, perr0, 1'b0);
    chk({tag, "_ferr"}, ferr0, 1'b0);
    chk({tag, "_ovr"},  ovr0,  1'b0);
  endtask

  initial begin
    logic [7:0] d;
    rdy_m = '{1'b0, 1'b0};
    ovr_m = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk_zero0("reset0");
    chk("reset2_rdy", rdy2, 1'b0);
    chk("reset2_data", data2, 8'h00);
    chk("reset2_perr", perr2, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Latency: 2 sync edges + IDLE detect edge, then BAUD_DIV/2 + frame_bits*BAUD_DIV + 1.
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    chk("lat_a5", rise_cyc[0] - start_cyc[0], 4 + H + (1 + N) * D + 1 - 1);
    check_out("a5");
    do_clr("clr_a5");

    send_frame(1'b1, 8'h07, 1'b0, 1'b1);
    chk("lat_07", rise_cyc[1] - start_cyc[1], 4 + H + (1 + N + 1) * D);
    check_out("p07_bad");
    do_clr("clr_p07a");
    send_frame(1'b1, 8'h07, 1'b1, 1'b1);
    check_out("p07_good");
    do_clr("clr_p07b");
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(1'b1, d, ^d, 1'b1);
      check_out("p_rand");
      do_clr("clr_prand");
    end

    // Glitch shorter than half a bit must be rejected as a false start.
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (3 * D) @(negedge clk);
    chk("glitch_rdy", rdy0, rdy_m[0]);

    send_frame(1'b0, 8'h96, 1'b0, 1'b0);
    check_out("brk_frame");
    do_clr("clr_brk");
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    chk("brk_nodec", rdy0, rdy_m[0]);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    check_out("after_brk");
    do_clr("clr_3c");

    send_frame(1'b0, 8'h11, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1);
    check_out("ovr");
    do_clr("clr_ovr");

    // Leave a word pending, then reset in the middle of data bit 3 of the next frame.
    send_frame(1'b0, 8'hE7, 1'b0, 1'b1);
    check_out("pre_rst");
    d = 8'hC3;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, d[i]);
    rx0 = d[3];
    repeat (D / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero0("mid_rst");
    rx0 = 1'b1;
    rdy_m = '{1'b0, 1'b0};
    ovr_m = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * D) @(negedge clk);
    chk("post_rst_rdy", rdy0, rdy_m[0]);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
    check_out("post_rst_5a");

    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL provide parameter BAUD_DIV, default 2604, clock cycles per bit (legal range 8..4095).
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 SHALL provide parameter PARITY, default 0, parity mode (0 = none, 1 = odd, 2 = even).
REQ-004 SHALL provide port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL provide port RX, input, 1, asynchronous serial line; idle high.
REQ-007 SHALL provide port clr_rdy, input, 1, consumer acknowledge; clears rdy and overrun.
REQ-008 SHALL provide port rx_data, output, DATA_BITS, last received data word, LSB = first bit received.
REQ-009 SHALL provide port rdy, output, 1, a new word is available in rx_data.
REQ-010 SHALL provide port parity_err, output, 1, parity mismatch in the word held in rx_data; constant 0 when PARITY = 0.
REQ-011 SHALL provide port frame_err, output, 1, stop bit sampled low for the word held in rx_data.
REQ-012 SHALL provide port overrun, output, 1, sticky flag: a word completed while rdy was already 1.

Function
REQ-013 SHALL pass RX through two flops reset to 1; all decisions use the second flop's output (rx_s).
REQ-014 SHALL implement states IDLE, START, DATA, PAR, STOP and BREAK.
REQ-015 SHALL hold a baud counter of clog2(BAUD_DIV) bits; in IDLE it is preset to BAUD_DIV/2 (integer division), and in every other state except BREAK it decrements by 1 per cycle.
REQ-016 SHALL treat baud counter == 0 as a sample point and reload the counter with BAUD_DIV-1 on that same cycle.
REQ-017 SHALL move from IDLE to START on the first cycle rx_s == 0.
REQ-018 SHALL check rx_s at the START sample point: if rx_s == 1, it is a false start, the block returns to IDLE, and no output changes; otherwise it moves to DATA with bit counter = 0.
REQ-019 SHALL shift rx_s into the data shift register at each DATA sample point, LSB first; after DATA_BITS samples it moves to PAR when PARITY != 0, otherwise to STOP.
REQ-020 SHALL sample one parity bit in PAR; the error is XOR of data bits and parity bit equal to 0 for odd mode, or equal to 1 for even mode.
REQ-021 SHALL perform these actions at the STOP sample point on the same clock edge: load rx_data from the shift register; load parity_err and frame_err for this frame (frame_err = !rx_s); set rdy to 1; set overrun to 1 if rdy was already 1.
REQ-022 SHALL go from STOP to IDLE if rx_s == 1, otherwise to BREAK.
REQ-023 SHALL remain in BREAK until rx_s == 1, then go to IDLE; it accepts no start bit while in BREAK.
REQ-024 SHALL, when clr_rdy is 1, clear rdy and overrun on the next edge; if the STOP sample point coincides with clr_rdy, the new word wins (rdy = 1) and overrun is unchanged by clr_rdy.
REQ-025 SHALL leave rx_data, parity_err and frame_err unchanged except at a STOP sample point, so they remain stable while rdy = 1.
REQ-026 SHALL assert rdy exactly BAUD_DIV/2 + (1+DATA_BITS+(PARITY!=0))*BAUD_DIV + 1 cycles after the first cycle rx_s == 0 is seen in IDLE.
REQ-027 SHALL overwrite rx_data with the newer word on overrun.

Reset
REQ-028 SHALL, while rst_n == 0, force the following regardless of clk: state IDLE; both sync flops 1; baud counter BAUD_DIV/2; bit counter 0; rx_data 0; rdy 0; parity_err 0; frame_err 0; overrun 0.
REQ-029 SHALL, when reset is asserted mid-frame, discard the partial frame and not assert rdy for it after release.

Verification
REQ-030 SHALL cover: BAUD_DIV=16, DATA_BITS=8, PARITY=0, frame 0xA5 -> rdy=1, rx_data=0xA5, flags 0, at the cycle count from REQ-026.
REQ-031 SHALL cover: PARITY=2, byte 0x07 with parity bit 0 (wrong) -> rdy=1, rx_data=0x07, parity_err=1; the same byte with parity bit 1 -> parity_err=0.
REQ-032 SHALL cover: a low pulse of 4 cycles on RX (< BAUD_DIV/2) -> block returns to IDLE, rdy stays 0.
REQ-033 SHALL cover: stop bit held low with RX low for 3 more bit times, then high, then frame 0x3C -> first frame gives frame_err=1; no frame decoded during the low period; next frame gives rx_data=0x3C, frame_err=0.
REQ-034 SHALL cover: two back-to-back frames 0x11, 0x22 with no clr_rdy -> rx_data=0x22, rdy=1, overrun=1; then clr_rdy -> rdy=0, overrun=0.
REQ-035 SHALL cover: rst_n pulsed low during data bit 3 -> all outputs 0 immediately; a clean frame 0x5A afterwards decodes correctly.
